// File: rtl/codec_stream_bridge.sv
// ---------------------------------------------------------------------------
// codec_stream_bridge
//
// Sample-rate bridge between the audio codec parallel sample interface and the
// DSP streaming datapath, all in the codec master-clock domain.
//
//  ADC side : every sample tick captures i_adc_sample into a small RX FIFO that
//             the DSP drains through a first-word-fall-through valid/ready port.
//  DAC side : the DSP pushes processed words into a TX FIFO; one word is
//             released per sample tick onto o_dac_sample, which the codec
//             latches on its next tick. A two-state PRIME/RUN machine refills
//             the FIFO to half depth after start-up or starvation before it
//             starts releasing samples again.
//  Loopback : the DAC word follows the ADC word directly; the TX FIFO and the
//             PRIME/RUN machine are left untouched.
//  Errors   : saturating counters for dropped ADC samples (overrun) and
//             starved DAC ticks (underrun).
//
// Ports
//  i_clk          system clock (codec MCLK domain)
//  i_rst          synchronous active-high reset
//  i_sample_tick  one-cycle pulse per stereo frame
//  i_adc_sample   parallel ADC word, valid with the tick
//  o_dac_sample   parallel DAC word, updates only in the cycle after a tick
//  o_rx_data      RX FIFO head (first-word-fall-through)
//  o_rx_valid     RX FIFO not empty
//  i_rx_ready     DSP takes the head when valid & ready
//  i_tx_data      DSP processed sample
//  i_tx_valid     DSP offers a sample, accepted when valid & o_tx_ready
//  o_tx_ready     TX FIFO not full
//  i_loopback     1: DAC word is the ADC word, TX FIFO bypassed
//  i_clr_cnt      synchronous clear of both error counters
//  o_rx_level     RX occupancy
//  o_tx_level     TX occupancy
//  o_overrun_cnt  RX drop count, saturating
//  o_underrun_cnt TX starvation count, saturating
// ---------------------------------------------------------------------------
module codec_stream_bridge #(
  parameter int DATA_W    = 24,
  parameter int ADC_DEPTH = 4,
  parameter int DAC_DEPTH = 4,
  parameter int CNT_W     = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_sample_tick,
  input  logic [DATA_W-1:0]            i_adc_sample,
  output logic [DATA_W-1:0]            o_dac_sample,
  output logic [DATA_W-1:0]            o_rx_data,
  output logic                         o_rx_valid,
  input  logic                         i_rx_ready,
  input  logic [DATA_W-1:0]            i_tx_data,
  input  logic                         i_tx_valid,
  output logic                         o_tx_ready,
  input  logic                         i_loopback,
  input  logic                         i_clr_cnt,
  output logic [$clog2(ADC_DEPTH):0]   o_rx_level,
  output logic [$clog2(DAC_DEPTH):0]   o_tx_level,
  output logic [CNT_W-1:0]             o_overrun_cnt,
  output logic [CNT_W-1:0]             o_underrun_cnt
);

  localparam int RX_AW = $clog2(ADC_DEPTH);
  localparam int TX_AW = $clog2(DAC_DEPTH);

  localparam logic [RX_AW:0] RX_ONE  = (RX_AW+1)'(1);
  localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(ADC_DEPTH);
  localparam logic [TX_AW:0] TX_ONE  = (TX_AW+1)'(1);
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(DAC_DEPTH);
  localparam logic [TX_AW:0] TX_HALF = (TX_AW+1)'(DAC_DEPTH / 2);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // -------------------------------------------------------------------------
  // RX FIFO (ADC -> DSP)
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] rx_mem [ADC_DEPTH];
  logic [RX_AW:0]    rx_wr_ptr_reg;
  logic [RX_AW:0]    rx_rd_ptr_reg;
  logic [RX_AW:0]    rx_level;
  logic              rx_full;
  logic              rx_pop;
  logic              rx_push;
  logic              overrun_evt;

  assign rx_level   = rx_wr_ptr_reg - rx_rd_ptr_reg;
  assign rx_full    = (rx_level == RX_FULL);
  assign o_rx_valid = !i_rst && (rx_level != '0);
  assign o_rx_data  = rx_mem[rx_rd_ptr_reg[RX_AW-1:0]];
  assign rx_pop     = o_rx_valid && i_rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  // the new sample when the DSP is reading.
  assign rx_push    = i_sample_tick && !i_rst && (!rx_full || rx_pop);
  // When full with no pop the new sample is dropped and the oldest kept.
  assign overrun_evt = i_sample_tick && !i_rst && rx_full && !rx_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
    end else begin
      if (rx_push) rx_wr_ptr_reg <= rx_wr_ptr_reg + RX_ONE;
      if (rx_pop)  rx_rd_ptr_reg <= rx_rd_ptr_reg + RX_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_reg[RX_AW-1:0]] <= i_adc_sample;
  end

  // -------------------------------------------------------------------------
  // TX FIFO (DSP -> DAC)
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] tx_mem [DAC_DEPTH];
  logic [TX_AW:0]    tx_wr_ptr_reg;
  logic [TX_AW:0]    tx_rd_ptr_reg;
  logic [TX_AW:0]    tx_level;
  logic              tx_empty;
  logic              tx_push;
  logic              tx_pop;

  assign tx_level   = tx_wr_ptr_reg - tx_rd_ptr_reg;
  assign tx_empty   = (tx_level == '0);
  assign o_tx_ready = !i_rst && (tx_level != TX_FULL);
  assign tx_push    = i_tx_valid && o_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_reg <= tx_wr_ptr_reg + TX_ONE;
      if (tx_pop)  tx_rd_ptr_reg <= tx_rd_ptr_reg + TX_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_reg[TX_AW-1:0]] <= i_tx_data;
  end

  // -------------------------------------------------------------------------
  // DAC release machine
  // PRIME outputs silence until the FIFO holds half its depth, which gives
  // the DSP a cushion of jitter tolerance before samples start draining.
  // The pop decision looks only at registered occupancy, so a word pushed in
  // a tick cycle is not visible to that tick.
  // -------------------------------------------------------------------------
  typedef enum logic {ST_PRIME, ST_RUN} dac_state_t;

  dac_state_t        state_reg;
  dac_state_t        state_next;
  logic [DATA_W-1:0] dac_reg;
  logic [DATA_W-1:0] dac_next;
  logic              underrun_evt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_PRIME;
      dac_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dac_reg   <= dac_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    dac_next     = dac_reg;
    tx_pop       = 1'b0;
    underrun_evt = 1'b0;
    if (i_loopback) begin
      // Machine frozen; the ADC word goes straight to the DAC.
      if (i_sample_tick) dac_next = i_adc_sample;
    end else begin
      unique case (state_reg)
        ST_PRIME: begin
          if (i_sample_tick) dac_next = '0;
          if (tx_level >= TX_HALF) state_next = ST_RUN;
        end
        ST_RUN: begin
          if (i_sample_tick) begin
            if (!tx_empty) begin
              tx_pop   = 1'b1;
              dac_next = tx_mem[tx_rd_ptr_reg[TX_AW-1:0]];
            end else begin
              // Starved: hold the last word and refill before resuming.
              underrun_evt = 1'b1;
              state_next   = ST_PRIME;
            end
          end
        end
        default: state_next = ST_PRIME;
      endcase
    end
  end

  assign o_dac_sample = dac_reg;

  // -------------------------------------------------------------------------
  // Saturating error counters; clear wins over a same-cycle event.
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] overrun_cnt_reg;
  logic [CNT_W-1:0] underrun_cnt_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_cnt) begin
      overrun_cnt_reg  <= '0;
      underrun_cnt_reg <= '0;
    end else begin
      if (overrun_evt && (overrun_cnt_reg != '1))
        overrun_cnt_reg <= overrun_cnt_reg + CNT_ONE;
      if (underrun_evt && (underrun_cnt_reg != '1))
        underrun_cnt_reg <= underrun_cnt_reg + CNT_ONE;
    end
  end

  assign o_overrun_cnt  = overrun_cnt_reg;
  assign o_underrun_cnt = underrun_cnt_reg;
  assign o_rx_level     = rx_level;
  assign o_tx_level     = tx_level;

endmodule

// File: tb/tb_codec_stream_bridge.sv
module tb_codec_stream_bridge;

  localparam int DATA_W    = 24;
  localparam int ADC_DEPTH = 4;
  localparam int DAC_DEPTH = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tick;
  logic [DATA_W-1:0] adc;
  logic [DATA_W-1:0] dac;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              loopback;
  logic              clr_cnt;
  logic [2:0]        rx_level;
  logic [2:0]        tx_level;
  logic [CNT_W-1:0]  ovr_cnt;
  logic [CNT_W-1:0]  und_cnt;

  codec_stream_bridge #(
    .DATA_W(DATA_W), .ADC_DEPTH(ADC_DEPTH), .DAC_DEPTH(DAC_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sample_tick(tick), .i_adc_sample(adc),
    .o_dac_sample(dac), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
    .i_rx_ready(rx_ready), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
    .o_tx_ready(tx_ready), .i_loopback(loopback), .i_clr_cnt(clr_cnt),
    .o_rx_level(rx_level), .o_tx_level(tx_level),
    .o_overrun_cnt(ovr_cnt), .o_underrun_cnt(und_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------
  // Reference model: behaviour described as queues and counts.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] m_rx_q[$];
  logic [DATA_W-1:0] m_tx_q[$];
  logic [DATA_W-1:0] sb_rx[$];   // expected stream for the DSP side
  logic [DATA_W-1:0] m_dac;
  bit                m_run;
  int                m_ovr, m_und;
  int                m_pre;
  bit                m_ovr_evt, m_und_evt;
  int                cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_rx_q.delete(); m_tx_q.delete(); sb_rx.delete();
      m_dac = '0; m_run = 0; m_ovr = 0; m_und = 0;
    end else begin
      m_ovr_evt = 0;
      m_und_evt = 0;
      // DSP read happens if data was available and it asked for it.
      if (m_rx_q.size() > 0 && rx_ready) void'(m_rx_q.pop_front());
      if (tick) begin
        if (m_rx_q.size() < ADC_DEPTH) begin
          m_rx_q.push_back(adc);
          sb_rx.push_back(adc);
        end else m_ovr_evt = 1;
      end
      // DAC side uses the occupancy before this cycle's push.
      m_pre = m_tx_q.size();
      if (loopback) begin
        if (tick) m_dac = adc;
      end else if (!m_run) begin
        if (tick) m_dac = '0;
        if (m_pre >= DAC_DEPTH / 2) m_run = 1;
      end else if (tick) begin
        if (m_pre > 0) m_dac = m_tx_q.pop_front();
        else begin
          m_und_evt = 1;
          m_run = 0;
        end
      end
      if (tx_valid && m_pre < DAC_DEPTH) m_tx_q.push_back(tx_data);
      if (clr_cnt) begin
        m_ovr = 0; m_und = 0;
      end else begin
        if (m_ovr_evt && m_ovr < CNT_MAX) m_ovr++;
        if (m_und_evt && m_und < CNT_MAX) m_und++;
      end
    end
  end

  // ------------------------------------------------------------------
  // Monitor: compares every cycle on the falling edge.
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] exp_word;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("rx_valid", 32'(rx_valid), 32'(!rst && m_rx_q.size() > 0));
      check("tx_ready", 32'(tx_ready), 32'(!rst && m_tx_q.size() < DAC_DEPTH));
      check("rx_level", 32'(rx_level), 32'(m_rx_q.size()));
      check("tx_level", 32'(tx_level), 32'(m_tx_q.size()));
      check("dac_sample", 32'(dac), 32'(m_dac));
      check("overrun_cnt", 32'(ovr_cnt), 32'(m_ovr));
      check("underrun_cnt", 32'(und_cnt), 32'(m_und));
      if (rx_valid && rx_ready) begin
        if (sb_rx.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL rx_pop: got %0h expected no data", rx_data);
        end else begin
          exp_word = sb_rx.pop_front();
          check("rx_data", 32'(rx_data), 32'(exp_word));
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Stimulus
  // ------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick(input logic [DATA_W-1:0] v);
    tick = 1'b1; adc = v;
    step();
    tick = 1'b0;
    step();
  endtask

  logic [CNT_W-1:0] ovr_before;
  bit last_tick;

  initial begin
    rst = 1'b1; tick = 1'b0; adc = '0; rx_ready = 1'b0; tx_data = '0;
    tx_valid = 1'b0; loopback = 1'b0; clr_cnt = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    check("reset_rx_valid", 32'(rx_valid), 32'h0);
    check("reset_tx_ready", 32'(tx_ready), 32'h1);
    check("reset_dac", 32'(dac), 32'h0);
    check("reset_levels", 32'({rx_level, tx_level}), 32'h0);

    // 1: three samples then drain
    do_tick(24'h000001); do_tick(24'h000002); do_tick(24'h000003);
    check("t1_rx_level", 32'(rx_level), 32'd3);
    check("t1_head", 32'(rx_data), 32'h1);
    rx_ready = 1'b1;
    step(); check("t1_second", 32'(rx_data), 32'h2);
    step(); check("t1_third", 32'(rx_data), 32'h3);
    step(); check("t1_valid_drop", 32'(rx_valid), 32'h0);
    rx_ready = 1'b0;

    // 2: overrun keeps the oldest four
    for (int i = 0; i < 6; i++) do_tick(DATA_W'(32'h10 + i));
    check("t2_rx_level", 32'(rx_level), 32'd4);
    check("t2_overrun", 32'(ovr_cnt), 32'd2);
    check("t2_head", 32'(rx_data), 32'h10);
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // 3: prime, run, underrun
    tx_valid = 1'b1; tx_data = 24'h100000; step();
    tx_data = 24'h200000; step();
    tx_valid = 1'b0; step();
    check("t3_tx_level", 32'(tx_level), 32'd2);
    do_tick(24'h000031); check("t3_dac0", 32'(dac), 32'h100000);
    do_tick(24'h000032); check("t3_dac1", 32'(dac), 32'h200000);
    do_tick(24'h000033);
    check("t3_underrun", 32'(und_cnt), 32'd1);
    check("t3_dac_hold", 32'(dac), 32'h200000);
    tx_valid = 1'b1; tx_data = 24'h300000; step(); tx_valid = 1'b0;
    do_tick(24'h000034);
    check("t3_prime_silence", 32'(dac), 32'h0);
    check("t3_no_pop", 32'(tx_level), 32'd1);

    // 4: loopback
    loopback = 1'b1;
    do_tick(24'hABCDEF);
    check("t4_loop_dac", 32'(dac), 32'hABCDEF);
    check("t4_tx_level", 32'(tx_level), 32'd1);
    loopback = 1'b0;

    // 5: full tick+pop, saturation, clear
    step(); step();
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_tick(DATA_W'(32'h20 + i));
    check("t5_full", 32'(rx_level), 32'd4);
    ovr_before = ovr_cnt;
    rx_ready = 1'b1; tick = 1'b1; adc = 24'h000055;
    step();
    rx_ready = 1'b0; tick = 1'b0;
    step();
    check("t5_level_same", 32'(rx_level), 32'd4);
    check("t5_no_overrun", 32'(ovr_cnt), 32'(ovr_before));
    for (int i = 0; i < 260; i++) do_tick(DATA_W'($urandom));
    check("t5_saturated", 32'(ovr_cnt), 32'hFF);
    clr_cnt = 1'b1; tick = 1'b1;
    step();
    clr_cnt = 1'b0; tick = 1'b0;
    step();
    check("t5_clr_ovr", 32'(ovr_cnt), 32'h0);
    check("t5_clr_und", 32'(und_cnt), 32'h0);

    // 6: reset mid-operation
    rx_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rx_ready = 1'b0;
    do_tick(24'h000061); do_tick(24'h000062);
    tx_valid = 1'b1; tx_data = 24'h400000; step(); tx_valid = 1'b0;
    check("t6_rx_two", 32'(rx_level), 32'd2);
    check("t6_tx_two", 32'(tx_level), 32'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(rx_valid), 32'h0);
    check("t6_rst_ready", 32'(tx_ready), 32'h0);
    step();
    rst = 1'b0;
    #1;
    check("t6_levels", 32'({rx_level, tx_level}), 32'h0);
    check("t6_dac", 32'(dac), 32'h0);
    tx_valid = 1'b1; tx_data = 24'h500000; step();
    tx_data = 24'h600000; tick = 1'b1; adc = 24'h000070; step();
    tx_valid = 1'b0; tick = 1'b0; step();
    check("t6_prime_after_rst", 32'(dac), 32'h0);

    // Randomised traffic; the monitor checks every cycle.
    last_tick = 0;
    for (int i = 0; i < 3000; i++) begin
      tick     = !last_tick && ($urandom_range(0, 2) == 0);
      last_tick = tick;
      adc      = DATA_W'($urandom);
      rx_ready = ($urandom_range(0, 3) != 0);
      tx_valid = ($urandom_range(0, 2) != 0);
      tx_data  = DATA_W'($urandom);
      if ($urandom_range(0, 99) == 0) loopback = ~loopback;
      clr_cnt  = ($urandom_range(0, 149) == 0);
      rst      = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; tick = 1'b0; tx_valid = 1'b0; clr_cnt = 1'b0;
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
